// File: rtl/lsu_if.sv
// lsu_if: execute->LSU bus, AXI R/B response channels and LSU->writeback bus.
//   master : upstream / memory side (drives exu_*, rvalid/rdata/rresp, bvalid/bresp)
//   slave  : the LSU (drives ready_o, rready_o, bready_o, lsu_wbu_bus_o, valid_o)
// Bus widths: EXU_LSU_BUS_WIDTH = 194, LSU_WBU_BUS_WIDTH = 152.
interface lsu_if;
  logic         exu_valid_i;
  logic         exu_issue_i;
  logic [193:0] exu_lsu_bus_i;
  logic         ready_o;
  logic         rvalid_i;
  logic [31:0]  rdata_i;
  logic [1:0]   rresp_i;
  logic         rready_o;
  logic         bvalid_i;
  logic [1:0]   bresp_i;
  logic         bready_o;
  logic [151:0] lsu_wbu_bus_o;
  logic         valid_o;

  modport master (
    output exu_valid_i, exu_issue_i, exu_lsu_bus_i,
    output rvalid_i, rdata_i, rresp_i, bvalid_i, bresp_i,
    input  ready_o, rready_o, bready_o, lsu_wbu_bus_o, valid_o
  );
  modport slave (
    input  exu_valid_i, exu_issue_i, exu_lsu_bus_i,
    input  rvalid_i, rdata_i, rresp_i, bvalid_i, bresp_i,
    output ready_o, rready_o, bready_o, lsu_wbu_bus_o, valid_o
  );
endinterface

// File: rtl/lsu.sv
// lsu: load/store stage. Captures the execute bus, waits for the AXI R or B
// beat (one access outstanding), aligns/extends load data, resolves rd_wdata
// and emits one single-cycle record per instruction to writeback.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   io     - lsu_if.slave (execute bus, AXI R/B, writeback bus)
// Optional feature: LSU_ACCESS_FAULT_EN -- non-OKAY rresp/bresp raises
// access_fault and suppresses gr_we in that record.
module lsu (
  input  logic  clock,
  input  logic  reset,
  lsu_if.slave  io
);
  typedef struct packed {
    logic [31:0] csr_wdata;
    logic        res_from_compare;
    logic        compare_result;
    logic [31:0] snpc;
    logic        csr_we;
    logic [1:0]  mem_addr_mask;
    logic [3:0]  mem_re;
    logic        mem_we;
    logic [11:0] csr_addr;
    logic [31:0] alu_result;
    logic [31:0] csr_value;
    logic        res_from_mem;
    logic        res_from_csr;
    logic        gr_we;
    logic [4:0]  rd;
    logic        excp_flush;
    logic        xret_flush;
    logic        break_signal;
    logic        jmp_flag;
    logic [31:0] jmp_target;
  } exu_bus_t;

  typedef struct packed {
    logic        access_fault;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic        gr_we;
    logic [4:0]  rd;
    logic [31:0] rd_wdata;
    logic        excp_flush;
    logic        xret_flush;
    logic        break_signal;
    logic        jmp_flag;
    logic [31:0] jmp_target;
    logic [31:0] snpc;
  } wbu_bus_t;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_R = 2'd1, WAIT_B = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  exu_bus_t    ex_q;
  exu_bus_t    ex_in;
  logic [31:0] rdata_q;
  logic [1:0]  resp_q;
  logic        in_fire;

  assign ex_in       = io.exu_lsu_bus_i;
  assign io.ready_o  = (state == IDLE) | (state == DONE);
  assign io.rready_o = (state == WAIT_R);
  assign io.bready_o = (state == WAIT_B);
  assign io.valid_o  = (state == DONE);
  assign in_fire     = io.exu_valid_i & io.exu_issue_i & io.ready_o;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ex_q    <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (in_fire) begin
            ex_q    <= ex_in;
            // Clear stale response so a non-memory op never inherits a fault.
            rdata_q <= '0;
            resp_q  <= '0;
            if (|ex_in.mem_re)    state <= WAIT_R;
            else if (ex_in.mem_we) state <= WAIT_B;
            else                   state <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_R: if (io.rvalid_i) begin
          rdata_q <= io.rdata_i;
          resp_q  <= io.rresp_i;
          state   <= DONE;
        end
        WAIT_B: if (io.bvalid_i) begin
          resp_q <= io.bresp_i;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0] shifted, load_data, rd_wdata;
  logic        fault;

  assign shifted = rdata_q >> {ex_q.mem_addr_mask, 3'b000};

  always_comb begin
    load_data = '0;
    case (ex_q.mem_re)
      4'b1111: load_data = shifted;
      4'b0011: load_data = {{16{shifted[15]}}, shifted[15:0]};
      4'b0111: load_data = {16'b0, shifted[15:0]};
      4'b0001: load_data = {{24{shifted[7]}}, shifted[7:0]};
      4'b0101: load_data = {24'b0, shifted[7:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    rd_wdata = ex_q.alu_result;
    if (ex_q.res_from_mem)          rd_wdata = load_data;
    else if (ex_q.res_from_csr)     rd_wdata = ex_q.csr_value;
    else if (ex_q.res_from_compare) rd_wdata = {31'b0, ex_q.compare_result};
  end

`ifdef LSU_ACCESS_FAULT_EN
  assign fault = |resp_q;
`else
  logic unused_resp;
  assign unused_resp = ^resp_q;
  assign fault       = 1'b0;
`endif

  wbu_bus_t wb;
  always_comb begin
    wb              = '0;
    wb.access_fault = fault;
    wb.csr_wdata    = ex_q.csr_wdata;
    wb.csr_we       = ex_q.csr_we;
    wb.csr_addr     = ex_q.csr_addr;
    wb.gr_we        = ex_q.gr_we & ~fault;
    wb.rd           = ex_q.rd;
    wb.rd_wdata     = rd_wdata;
    wb.excp_flush   = ex_q.excp_flush;
    wb.xret_flush   = ex_q.xret_flush;
    wb.break_signal = ex_q.break_signal;
    wb.jmp_flag     = ex_q.jmp_flag;
    wb.jmp_target   = ex_q.jmp_target;
    wb.snpc         = ex_q.snpc;
  end
  assign io.lsu_wbu_bus_o = wb;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven vectors with a scoreboard of expected writeback
// records, plus hand-written sequences for reset, back-to-back and stray beats.
module tb_lsu;
  typedef struct packed {
    logic [31:0] csr_wdata;
    logic        res_from_compare;
    logic        compare_result;
    logic [31:0] snpc;
    logic        csr_we;
    logic [1:0]  mem_addr_mask;
    logic [3:0]  mem_re;
    logic        mem_we;
    logic [11:0] csr_addr;
    logic [31:0] alu_result;
    logic [31:0] csr_value;
    logic        res_from_mem;
    logic        res_from_csr;
    logic        gr_we;
    logic [4:0]  rd;
    logic        excp_flush;
    logic        xret_flush;
    logic        break_signal;
    logic        jmp_flag;
    logic [31:0] jmp_target;
  } exu_t;

  typedef struct packed {
    logic        access_fault;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic        gr_we;
    logic [4:0]  rd;
    logic [31:0] rd_wdata;
    logic        excp_flush;
    logic        xret_flush;
    logic        break_signal;
    logic        jmp_flag;
    logic [31:0] jmp_target;
    logic [31:0] snpc;
  } wbu_t;

  typedef struct {
    logic [3:0]  re;
    logic        we;
    logic [1:0]  mask;
    logic        fm, fc, fcmp, cmpr, grwe;
    logic [31:0] alu, csrv, rdata;
    logic [1:0]  resp;
    int          dly;
    logic [31:0] exp_rd;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lsu_if io();
  lsu u_dut (.clock(clock), .reset(reset), .io(io));

  int   n_vec = 0;
  int   n_err = 0;
  wbu_t sb[$];

  task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid_o pulse must match the oldest pending record.
  always begin
    @(posedge clock);
    #1;
    if (reset && io.valid_o) begin
      if (sb.size() == 0) chk("unexpected_valid", 152'(io.valid_o), 152'(0));
      else begin
        wbu_t e;
        e = sb.pop_front();
        chk("wb_record", io.lsu_wbu_bus_o, e);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  function automatic exu_t build(input vec_t v);
    exu_t e;
    logic [223:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    e = r[193:0];
    e.mem_re           = v.re;
    e.mem_we           = v.we;
    e.mem_addr_mask    = v.mask;
    e.res_from_mem     = v.fm;
    e.res_from_csr     = v.fc;
    e.res_from_compare = v.fcmp;
    e.compare_result   = v.cmpr;
    e.gr_we            = v.grwe;
    e.alu_result       = v.alu;
    e.csr_value        = v.csrv;
    return e;
  endfunction

  function automatic wbu_t expect_of(input exu_t e, input vec_t v);
    wbu_t w;
    logic f;
`ifdef LSU_ACCESS_FAULT_EN
    f = (v.resp != 2'b00) && ((v.re != 4'b0) || v.we);
`else
    f = 1'b0;
`endif
    w.access_fault = f;
    w.csr_wdata    = e.csr_wdata;
    w.csr_we       = e.csr_we;
    w.csr_addr     = e.csr_addr;
    w.gr_we        = e.gr_we & ~f;
    w.rd           = e.rd;
    w.rd_wdata     = v.exp_rd;
    w.excp_flush   = e.excp_flush;
    w.xret_flush   = e.xret_flush;
    w.break_signal = e.break_signal;
    w.jmp_flag     = e.jmp_flag;
    w.jmp_target   = e.jmp_target;
    w.snpc         = e.snpc;
    return w;
  endfunction

  // Issue one instruction; for hold=1 (non-memory only) leave upstream valid
  // asserted so the next call fires back-to-back.
  task automatic run_vec(input vec_t v, input bit hold);
    exu_t e;
    bit   is_r, is_b;
    e    = build(v);
    is_r = (v.re != 4'b0);
    is_b = !is_r && v.we;
    @(negedge clock);
    chk("ready_before_issue", 152'(io.ready_o), 152'(1));
    sb.push_back(expect_of(e, v));
    io.exu_valid_i   = 1'b1;
    io.exu_issue_i   = 1'b1;
    io.exu_lsu_bus_i = e;
    @(posedge clock);
    #1;
    if (!is_r && !is_b) begin
      chk("nonmem_latency", 152'(io.valid_o), 152'(1));
      if (hold) return;
    end
    @(negedge clock);
    io.exu_valid_i = 1'b0;
    io.exu_issue_i = 1'b0;
    if (is_r || is_b) begin
      for (int i = 0; i < v.dly; i++) begin
        chk(is_r ? "rready_wait" : "bready_wait",
            152'({io.rready_o, io.bready_o, io.ready_o, io.valid_o}),
            152'({is_r, is_b, 1'b0, 1'b0}));
        @(negedge clock);
      end
      if (is_r) begin
        io.rvalid_i = 1'b1; io.rdata_i = v.rdata; io.rresp_i = v.resp;
      end else begin
        io.bvalid_i = 1'b1; io.bresp_i = v.resp;
      end
      @(posedge clock);
      #1;
      chk("mem_latency", 152'(io.valid_o), 152'(1));
      @(negedge clock);
      io.rvalid_i = 1'b0; io.bvalid_i = 1'b0;
      io.rdata_i  = $urandom; io.rresp_i = 2'b00; io.bresp_i = 2'b00;
    end
  endtask

  vec_t vecs[13];
  vec_t v;

  initial begin
    //           re     we    mask   fm fc fcmp cmpr grwe alu           csrv          rdata         resp   dly exp_rd
    vecs[0]  = '{4'b0001, 1'b0, 2'd2, 1, 0, 0, 0, 1, 32'h0000_0001, 32'h0,        32'h1280_3456, 2'b00, 2, 32'hFFFF_FF80};
    vecs[1]  = '{4'b0111, 1'b0, 2'd2, 1, 0, 0, 0, 1, 32'h0000_0002, 32'h0,        32'h8001_0000, 2'b00, 0, 32'h0000_8001};
    vecs[2]  = '{4'b1111, 1'b0, 2'd0, 1, 0, 0, 0, 1, 32'h0000_0003, 32'h0,        32'hDEAD_BEEF, 2'b00, 1, 32'hDEAD_BEEF};
    vecs[3]  = '{4'b0011, 1'b0, 2'd0, 1, 1, 0, 0, 1, 32'h0,         32'h5555_5555, 32'h0000_F00F, 2'b00, 0, 32'hFFFF_F00F};
    vecs[4]  = '{4'b0101, 1'b0, 2'd3, 1, 0, 0, 0, 1, 32'h0,         32'h0,        32'hAB00_0000, 2'b00, 1, 32'h0000_00AB};
    vecs[5]  = '{4'b0011, 1'b0, 2'd1, 1, 0, 0, 0, 1, 32'h0,         32'h0,        32'h1234_5678, 2'b00, 0, 32'h0000_3456};
    vecs[6]  = '{4'b0010, 1'b0, 2'd0, 1, 0, 0, 0, 1, 32'h0,         32'h0,        32'hFFFF_FFFF, 2'b00, 0, 32'h0000_0000};
    vecs[7]  = '{4'b0000, 1'b0, 2'd0, 0, 1, 1, 1, 1, 32'h7777_0000, 32'hCAFE_0001, 32'h0,        2'b00, 0, 32'hCAFE_0001};
    vecs[8]  = '{4'b0000, 1'b0, 2'd0, 0, 0, 1, 1, 1, 32'h7777_0000, 32'h0,        32'h0,        2'b00, 0, 32'h0000_0001};
    vecs[9]  = '{4'b0000, 1'b0, 2'd0, 0, 0, 0, 1, 0, 32'h1111_2222, 32'h0,        32'h0,        2'b00, 0, 32'h1111_2222};
    vecs[10] = '{4'b0000, 1'b1, 2'd0, 0, 0, 0, 0, 1, 32'h0000_1000, 32'h0,        32'h0,        2'b00, 5, 32'h0000_1000};
    vecs[11] = '{4'b1111, 1'b0, 2'd0, 1, 0, 0, 0, 1, 32'h0,         32'h0,        32'h0BAD_0BAD, 2'b10, 1, 32'h0BAD_0BAD};
    vecs[12] = '{4'b0000, 1'b1, 2'd0, 0, 0, 0, 0, 1, 32'h0000_2000, 32'h0,        32'h0,        2'b11, 0, 32'h0000_2000};

    io.exu_valid_i = 0; io.exu_issue_i = 0; io.exu_lsu_bus_i = '0;
    io.rvalid_i = 0; io.rdata_i = 0; io.rresp_i = 0;
    io.bvalid_i = 0; io.bresp_i = 0;

    // Reset state
    #12;
    chk("reset_ctrl", 152'({io.valid_o, io.ready_o, io.rready_o, io.bready_o}), 152'(4'b0100));
    chk("reset_bus", io.lsu_wbu_bus_o, 152'(0));
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], 1'b0);

    // Back-to-back ALU ops: valid_o must stay high three consecutive cycles.
    for (int i = 1; i <= 3; i++) begin
      v = vecs[9];
      v.alu = 32'(i); v.exp_rd = 32'(i);
      run_vec(v, 1'b1);
    end
    @(negedge clock);
    chk("b2b_third_valid", 152'(io.valid_o), 152'(1));
    io.exu_valid_i = 0; io.exu_issue_i = 0;
    @(posedge clock); #1;
    chk("b2b_drop", 152'(io.valid_o), 152'(0));

    // Stray R/B beats while idle must not be acknowledged.
    @(negedge clock);
    io.rvalid_i = 1; io.bvalid_i = 1;
    #1;
    chk("stray_ready", 152'({io.rready_o, io.bready_o, io.ready_o}), 152'(3'b001));
    @(negedge clock);
    chk("stray_novalid", 152'(io.valid_o), 152'(0));
    io.rvalid_i = 0; io.bvalid_i = 0;

    // Response in the same cycle as in_fire is ignored: still waits for R.
    v = vecs[2];
    @(negedge clock);
    io.exu_valid_i = 1; io.exu_issue_i = 1; io.exu_lsu_bus_i = build(v);
    io.rvalid_i = 1; io.rdata_i = 32'h1234_5678;
    @(negedge clock);
    io.exu_valid_i = 0; io.exu_issue_i = 0; io.rvalid_i = 0;
    chk("early_r_ignored", 152'({io.rready_o, io.valid_o}), 152'(2'b10));

    // Reset mid-WAIT_R with rvalid low.
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midreset_ctrl", 152'({io.valid_o, io.ready_o, io.rready_o, io.bready_o}), 152'(4'b0100));
    chk("midreset_bus", io.lsu_wbu_bus_o, 152'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("postreset_idle", 152'({io.valid_o, io.ready_o, io.rready_o}), 152'(3'b010));

    // Machine resumes normally after reset.
    run_vec(vecs[0], 1'b0);
    repeat (3) @(negedge clock);
    chk("sb_drained", 152'(sb.size()), 152'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
